// File: rtl/contador_sincrono_decrescente_6bits.sv
// contador_sincrono_decrescente_6bits: free-running 6-bit synchronous down counter built from T cells
module t_cell (
  input  logic clk,
  input  logic RESET,
  input  logic t,
  output logic q
);
  logic q_q, q_d;
  // Toggle the stored bit when t is high
  always_comb q_d = q_q ^ t;
  // State flop with asynchronous active-low clear
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) q_q <= 1'b0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

module contador_sincrono_decrescente_6bits (
  input  logic       clk,
  output logic [5:0] q,
  input  logic       RESET
);
  logic [5:0] t;
  assign t[0] = 1'b1;
  for (genvar i = 0; i < 6; i++) begin : g_bit
    if (i > 0) begin : g_borrow
      assign t[i] = t[i-1] & ~q[i-1];
    end
    t_cell u_cell (.clk(clk), .RESET(RESET), .t(t[i]), .q(q[i]));
  end
endmodule

// File: tb/tb_contador_sincrono_decrescente_6bits.sv
// tb_contador_sincrono_decrescente_6bits: randomized self-checking bench with arithmetic reference model
`timescale 1ns/1ns
module tb_contador_sincrono_decrescente_6bits;
  logic clk = 1'b0;
  logic RESET = 1'b0;
  logic [5:0] q;
  int checks = 0;
  int errors = 0;
  int m = 0;
  bit found;

  contador_sincrono_decrescente_6bits dut (.clk(clk), .q(q), .RESET(RESET));

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m = RESET ? (m + 63) % 64 : 0;
  endtask

  initial begin
    #5;
    chk("reset_async", q, 6'd0);
    tick();
    chk("reset_hold", q, 6'd0);
    @(negedge clk);
    chk("reset_low", q, 6'd0);
    RESET = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      chk($sformatf("seq_%0d", i), q, 6'(63 - i));
      chk("model_seq", q, 6'(m));
    end
    tick();
    chk("wrap_65", q, 6'd63);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      found = (q == 6'd40);
    end
    chk("reach_40", q, 6'd40);
    #4;
    RESET = 1'b0;
    #1;
    m = 0;
    chk("mid_reset", q, 6'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_hold", q, 6'd0);
    end
    @(negedge clk);
    RESET = 1'b1;
    tick();
    chk("restart_63", q, 6'd63);
    tick();
    chk("restart_62", q, 6'd62);
    for (int i = 0; i < 200; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 7);
      if (r == 0) begin
        RESET = 1'b0;
        #1;
        m = 0;
        chk("rnd_assert", q, 6'd0);
      end else if (r == 1) begin
        RESET = 1'b0;
        #2;
        m = 0;
        chk("rnd_pulse", q, 6'd0);
        RESET = 1'b1;
      end else begin
        RESET = 1'b1;
      end
      tick();
      chk("rnd_model", q, 6'(m));
    end
    $display("Teste completo");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/contador_sincrono_decrescente_6bits.md
# contador_sincrono_decrescente_6bits

Free-running 6-bit synchronous down counter: on every rising clock edge the count decrements by one, wrapping from 0 to 63. It has no enable or load inputs; reset is the only control. It serves as a simple timebase or sequence source and as a reference structure for synchronous counters built from per-bit toggle cells.

## Interface
- Parameters: none; width is fixed at 6 bits.
- One clock; reset is asynchronous and active-low.
- `clk`  input  1  Clock. All state changes on its rising edge.
- `RESET`  input  1  Asynchronous, active-low reset. `RESET`=0 clears the count immediately, regardless of `clk`.
- `q`  output  6  Current count, unsigned, `q[0]` = LSB. Driven directly from the state flip-flops.
- Port order for positional instantiation: `clk`, `q`, `RESET`.

## Operation
- State: six flip-flops `q[5:0]`, all clocked by the same `clk`. This is a synchronous counter, not a ripple counter.
- Structure:
  - Each bit is a toggle (T) cell: a D flip-flop with an XOR feedback, plus an asynchronous active-low clear.
  - The cell is written as a submodule and instantiated six times.
- Toggle conditions (borrow chain):
  - T0 = 1.
  - T1 = ~q0.
  - Tn = ~q0 & ~q1 & … & ~q(n-1), for n = 2..5.
  - Generate each borrow as T(n) = T(n-1) & ~q(n-1). The chain is combinational and is sampled on the same edge.
- Next state: q_next = q − 1 mod 64.
- Wrap-around:
  - q = 0 → next edge gives 63 (6'b111111). All six bits toggle.
  - No terminal-count output and no saturation.
- Reset:
  - `RESET`=0 forces q = 6'b000000 asynchronously.
  - The count holds at 0 while `RESET` stays low, even with clock edges present.
- Reset release:
  - The first rising `clk` edge with `RESET`=1 moves q from 0 to 63.
  - Counting then continues 62, 61, … down to 0, then 63 again.
- Reset mid-count: asserting `RESET` at any point, including between clock edges, clears q to 0 at once. The interrupted value is lost.
- No X-propagation escape: after any reset assertion every bit is a known 0.

## Timing
- Latency: q changes one clock-to-Q delay after each rising `clk` edge. Exactly one decrement per edge.
- Period: the full sequence is 64 clocks.
- Reset assert: q goes to 0 within clock-to-Q of the `RESET` falling edge, with no clock needed.
- Reset deassert:
  - Deassert `RESET` away from the rising `clk` edge. Bench practice is to change it on the falling edge or mid-period.
  - If deassertion coincides with a rising edge, q must be either 0 or 63 afterwards, never any other value.
- Combinational path: the borrow chain is at most 5 AND levels. It must settle within one clock period.
- Simulation timescale: 1 ns / 1 ns.

## Test plan
- Reset then count:
  - Stimulus: `RESET`=0 for 20 ns, then 1, with a 20 ns clock period.
  - Required: q=0 during reset; then 63, 62, 61, 60 on the next four rising edges.
- Full cycle and wrap:
  - Stimulus: count 64 edges after reset release.
  - Required: q visits 63..0 in strictly decreasing order, each value exactly once. Edge 65 gives 63 again.
- Mid-period asynchronous reset:
  - Stimulus: at q=40, pull `RESET` low 5 ns after a rising edge.
  - Required: q=0 immediately, without waiting for the next edge. q stays 0 over 3 clock edges while low.
- Release and restart:
  - Stimulus: after the mid-count reset, raise `RESET`.
  - Required: the next edge gives 63, then 62.
- Borrow propagation:
  - Stimulus: check the transitions 32→31, 16→15 and 1→0.
  - Required: q = 6'b011111, 6'b001111 and 6'b000000 respectively. No glitch value is sampled at the edge.
- Randomized reset pulses:
  - Stimulus: 200 cycles with random `RESET` low pulses.
  - Required: a scoreboard model (q = 0 on reset, else q−1 mod 64) matches q every cycle. The bench prints "Teste completo" at the end.
